// File: rtl/isp_vga_out.sv
// Display-side stage: buffers the scaler's 640x480 greyscale stream in a small FIFO,
// generates 640x480@60 VGA timing and recovers from underflow or frame misalignment.
module isp_vga_out #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_in,
    input  logic       pix_in_sof,
    input  logic       pix_in_valid,
    output logic       pix_in_ready,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic [9:0] h_pixel,
    output logic [9:0] v_pixel,
    output logic       underflow,
    output logic       sync_err
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_SOF,
        FILL,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [3:0]    rgb_q, rgb_d;
    logic          underflow_q, underflow_d;
    logic          sync_err_q, sync_err_d;
    logic [8:0]    mem_q [FIFO_DEPTH];

    logic       active, frame_end, at_origin;
    logic       full, empty, accept, push, pop, flush;
    logic [8:0] head;

    // Free-running timing; these never look at the state machine.
    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    assign active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    assign at_origin = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign head         = mem_q[rd_ptr_q];
    assign pix_in_ready = (state_q == WAIT_SOF) ? 1'b1 : !full;
    assign accept       = pix_in_valid && pix_in_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        rgb_d       = 4'd0;
        underflow_d = underflow_q;
        sync_err_d  = sync_err_q;

        case (state_q)
            WAIT_SOF: begin
                if (accept && pix_in_sof) begin
                    push    = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                push = accept;
                if (frame_end) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                push = accept;
                if (active) begin
                    if (empty) begin
                        underflow_d = 1'b1;
                        flush       = 1'b1;
                        state_d     = WAIT_SOF;
                    end else begin
                        pop   = 1'b1;
                        rgb_d = head[7:4];
                        // A marker must appear exactly at (0,0); the pixel is still shown.
                        if (head[8] != at_origin) begin
                            sync_err_d = 1'b1;
                            flush      = 1'b1;
                            state_d    = WAIT_SOF;
                        end
                    end
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    // A flush discards everything, including a beat accepted in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        hsync_d = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vsync_d = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        de_d    = active;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_SOF;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            de_q        <= 1'b0;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= {pix_in_sof, pix_in};
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign vga_r     = rgb_q;
    assign vga_g     = rgb_q;
    assign vga_b     = rgb_q;
    assign h_pixel   = h_cnt_q;
    assign v_pixel   = v_cnt_q;
    assign underflow = underflow_q;
    assign sync_err  = sync_err_q;

endmodule
